uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
- TX-side counterpart to the UART receive-pump logic: accepts bytes from an on-chip producer over a valid/ready stream and buffers them in a FIFO.
- Drains the FIFO into the uart_wrap transmit interface (txempty/txdata/write), one byte per txempty window.
- Sits between any byte producer (command responder, log source) and uart_wrap, so producers never poll txempty.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries of 8 bits (legal 1..8).
- GUARD_CYCLES, 2, cycles after a write pulse during which txempty is ignored; covers uart_wrap's txempty deassert latency (legal 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  producer has a byte on in_data.
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO can accept; byte taken on an edge where in_valid & in_ready.
- flush  input  1  synchronous FIFO clear.
- txempty  input  1  from uart_wrap; transmitter can take a byte.
- txdata  output  8  to uart_wrap; byte being written.
- write  output  1  to uart_wrap; one-cycle write strobe.
- level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
- busy  output  1  high when level != 0 or FSM not in IDLE.

Behaviour:
- Reset (rst=0, async): level=0, rd/wr pointers=0, FSM=IDLE, write=0, txdata=8'h00, guard counter=0. Because level=0, in_ready=1 and busy=0 during and after reset. All outputs are registered except in_ready and busy, which decode from registers only; there is no combinational path from in_valid or txempty.
- FIFO:
  - Circular buffer with pointers of DEPTH_LOG2 bits that wrap naturally at depth.
  - in_ready = (level != depth).
  - Push when in_valid & in_ready.
  - Pop only by the FSM, as described below.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - Push when full: impossible since in_ready=0; in_valid is ignored and the producer must hold.
- FSM states: IDLE, GUARD.
  - IDLE: if level != 0 and txempty=1, then on that edge pop the head byte, load it into txdata, set write=1, load the guard counter with GUARD_CYCLES, and go to GUARD. Otherwise write=0.
  - GUARD: write=0 from the first GUARD cycle onward, so write is exactly one cycle wide. The counter decrements each cycle and txempty is ignored. When the counter reaches 0, go to IDLE.
  - Throughput limit: at most one write per GUARD_CYCLES+1 cycles.
- txdata holds its value from a write until the next write; it is never changed outside a write.
- Latency: for a byte pushed into an empty FIFO on edge N with txempty=1 and FSM in IDLE, write=1 and txdata=byte during cycle N+1→N+2.
- Ordering: strict FIFO order, with no drops or duplicates.
- flush=1 on an edge:
  - Pointers and level go to 0; any push on the same edge is discarded.
  - It does not cancel a write already asserted or the GUARD countdown, and txdata is unchanged.
  - flush takes priority over a pop on the same edge: if IDLE would fire on that edge, no write occurs.
- txempty dropping while in IDLE with data: stall, no write, and the data is retained.
- Asynchronous reset asserted mid-GUARD or mid-write: immediately returns to the reset values above, and FIFO contents are lost.
- level arithmetic: level_next = level + push − pop, with width DEPTH_LOG2+1, so it never overflows.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> level=0, in_ready=1, write=0, txdata=8'h00, busy=0.
- Single byte: txempty=1, push 8'h41 on edge N -> write=1 with txdata=8'h41 for exactly one cycle starting at N+1; level returns to 0; busy drops after GUARD_CYCLES more cycles.
- Burst and backpressure (DEPTH_LOG2=4): txempty=0, push 8'h00..8'h10 continuously -> 16 bytes accepted, in_ready=0 and level=16, and the 17th byte is held. Then raise txempty=1 -> writes emit 8'h00..8'h0F in order, spaced 3 cycles apart (GUARD_CYCLES=2), and 8'h10 is accepted when in_ready returns.
- Simultaneous push/pop at level=5: push on the same edge as an IDLE pop -> level stays 5 and the write carries the oldest byte.
- Flush: level=4, assert flush on the same edge IDLE would write -> no write, level=0, txdata unchanged. Flush one cycle after a write -> that write completes and level=0.
- Reset mid-GUARD: assert rst=0 one cycle after a write with level=3 -> write=0, level=0, txdata=8'h00 immediately. After release, no stale bytes are emitted.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte FIFO fed by a valid/ready producer, drained into the
// uart_wrap transmit interface one byte per txempty window. After each write
// the txempty input is ignored for GUARD_CYCLES cycles, because uart_wrap
// takes that long to drop txempty.
//
// state | meaning
// IDLE  | waiting for data and txempty; fires a one-cycle write
// GUARD | write issued; counting down GUARD_CYCLES, txempty ignored
module uart_tx_stream #(
  parameter int DEPTH_LOG2   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  txempty,
  output logic [7:0]            txdata,
  output logic                  write,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ZERO = '0;

  typedef enum logic {IDLE, GUARD} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [3:0]            guard_q, guard_d;
  logic                  write_q, write_d;
  logic [7:0]            txdata_q, txdata_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  push;
  logic                  pop;

  // in_ready and busy decode only from registers; no path from in_valid/txempty.
  assign in_ready = (level_q != LEVEL_FULL);
  assign busy     = (level_q != LEVEL_ZERO) || (state_q != IDLE);
  assign push     = in_valid && in_ready && !flush;
  assign txdata   = txdata_q;
  assign write    = write_q;
  assign level    = level_q;

  // FSM: fire a write from IDLE when data and txempty are present, then hold off.
  // flush suppresses the pop so a flushed byte is never sent.
  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    write_d  = 1'b0;
    txdata_d = txdata_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((level_q != LEVEL_ZERO) && txempty && !flush) begin
          pop      = 1'b1;
          write_d  = 1'b1;
          txdata_d = mem_q[rd_ptr_q];
          guard_d  = 4'(GUARD_CYCLES);
          state_d  = GUARD;
        end
      end
      GUARD: begin
        guard_d = (guard_q == 4'd0) ? 4'd0 : guard_q - 4'd1;
        if (guard_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; flush clears everything and drops a same-edge push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
  end

  // Control and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      guard_q  <= '0;
      write_q  <= 1'b0;
      txdata_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      guard_q  <= guard_d;
      write_q  <= write_d;
      txdata_q <= txdata_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: fixed vector table, directed corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_uart_tx_stream;

  localparam int DL    = 4;
  localparam int G     = 2;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          txempty = 1'b0;
  logic [7:0]    txdata;
  logic          write;
  logic [DL:0]   level;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_stream #(.DEPTH_LOG2(DL), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .txempty(txempty), .txdata(txdata),
    .write(write), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus "edges since last write" count.
  logic [7:0] mq[$];
  int         since;
  logic [7:0] m_tx;
  logic       m_wr;
  logic       m_acc;

  task automatic model_reset();
    mq.delete();
    since = G + 1;
    m_tx  = 8'h00;
    m_wr  = 1'b0;
    m_acc = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic te, input logic fl);
    logic fire;
    m_acc = v && (mq.size() < DEPTH) && !fl;
    fire  = (mq.size() > 0) && te && (since > G) && !fl;
    if (fire) begin
      m_tx  = mq.pop_front();
      m_wr  = 1'b1;
      since = 1;
    end else begin
      m_wr = 1'b0;
      if (since <= G) since++;
    end
    if (fl) mq.delete();
    else if (m_acc) mq.push_back(d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".write"},    32'(write),    32'(m_wr));
    chk({tag, ".txdata"},   32'(txdata),   32'(m_tx));
    chk({tag, ".level"},    32'(level),    32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".busy"},     32'(busy),     32'((mq.size() != 0) || (since <= G)));
  endtask

  // Apply inputs at a negedge, clock one rising edge, check at the next negedge.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic te, input logic fl);
    in_valid = v; in_data = d; txempty = te; flush = fl;
    @(posedge clk);
    model_edge(v, d, te, fl);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = 8'h00; txempty = 1'b0; flush = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.level",    32'(level),    32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.write",    32'(write),    32'd0);
    chk("rst.txdata",   32'(txdata),   32'h00);
    chk("rst.busy",     32'(busy),     32'd0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk_model("post_rst");
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       te;
    logic       fl;
    logic       e_wr;
    logic [7:0] e_tx;
    logic [DL:0] e_lvl;
    logic       e_rdy;
    logic       e_busy;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0] got[$];
    int         got_t[$];
    int         cur;
    logic [7:0] first;

    model_reset();

    //          v   d      te  fl  wr  tx     lvl  rdy busy
    vecs[0]  = '{1, 8'h41, 1, 0,  0, 8'h00, 1,   1,  1};
    vecs[1]  = '{0, 8'h00, 1, 0,  1, 8'h41, 0,   1,  1};
    vecs[2]  = '{0, 8'h00, 1, 0,  0, 8'h41, 0,   1,  1};
    vecs[3]  = '{0, 8'h00, 1, 0,  0, 8'h41, 0,   1,  0};
    vecs[4]  = '{1, 8'hA1, 0, 0,  0, 8'h41, 1,   1,  1};
    vecs[5]  = '{1, 8'hB2, 0, 0,  0, 8'h41, 2,   1,  1};
    vecs[6]  = '{0, 8'h00, 1, 0,  1, 8'hA1, 1,   1,  1};
    vecs[7]  = '{0, 8'h00, 1, 0,  0, 8'hA1, 1,   1,  1};
    vecs[8]  = '{0, 8'h00, 1, 0,  0, 8'hA1, 1,   1,  1};
    vecs[9]  = '{0, 8'h00, 1, 0,  1, 8'hB2, 0,   1,  1};
    vecs[10] = '{0, 8'h00, 0, 0,  0, 8'hB2, 0,   1,  1};
    vecs[11] = '{0, 8'h00, 0, 0,  0, 8'hB2, 0,   1,  0};
    vecs[12] = '{1, 8'hC3, 1, 1,  0, 8'hB2, 0,   1,  0};

    @(negedge clk);
    do_reset();

    // Vector table: single byte latency/guard, two-byte spacing, flush dropping a push.
    foreach (vecs[i]) begin
      step("vec", vecs[i].v, vecs[i].d, vecs[i].te, vecs[i].fl);
      chk($sformatf("vec%0d.write", i),    32'(write),    32'(vecs[i].e_wr));
      chk($sformatf("vec%0d.txdata", i),   32'(txdata),   32'(vecs[i].e_tx));
      chk($sformatf("vec%0d.level", i),    32'(level),    32'(vecs[i].e_lvl));
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(vecs[i].e_busy));
    end

    // Burst with backpressure, then drain in order with fixed spacing.
    do_reset();
    cur = 0;
    for (int c = 0; c < 20; c++) begin
      step("burst_fill", 1'b1, 8'(cur), 1'b0, 1'b0);
      if (m_acc) cur++;
    end
    chk("burst.level_full", 32'(level),    32'd16);
    chk("burst.in_ready",   32'(in_ready), 32'd0);
    for (int c = 0; c < 120 && got.size() < 17; c++) begin
      step("burst_drain", cur < 17, 8'(cur), 1'b1, 1'b0);
      if (m_acc) cur++;
      if (write) begin
        got.push_back(txdata);
        got_t.push_back(c);
      end
    end
    chk("burst.write_count", 32'(got.size()), 32'd17);
    foreach (got[i]) chk($sformatf("burst.order%0d", i), 32'(got[i]), 32'(i));
    for (int i = 1; i < got_t.size(); i++)
      chk($sformatf("burst.spacing%0d", i), 32'(got_t[i] - got_t[i-1]), 32'(G + 1));

    // Simultaneous push and pop at level 5.
    do_reset();
    for (int i = 0; i < 5; i++) step("pp_fill", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step("pp", 1'b1, 8'h99, 1'b1, 1'b0);
    chk("pushpop.level",  32'(level),  32'd5);
    chk("pushpop.write",  32'(write),  32'd1);
    chk("pushpop.txdata", 32'(txdata), 32'h60);

    // Flush on the edge IDLE would fire: no write, txdata held.
    do_reset();
    step("fl_pre", 1'b1, 8'h77, 1'b1, 1'b0);
    step("fl_pre", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush.prewrite", 32'(txdata), 32'h77);
    repeat (3) step("fl_wait", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("fl_fill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("flush.level4", 32'(level), 32'd4);
    step("fl", 1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush.write",  32'(write),  32'd0);
    chk("flush.level",  32'(level),  32'd0);
    chk("flush.txdata", 32'(txdata), 32'h77);
    // Flush one cycle after a write: the write stands, FIFO empties.
    step("fl2_fill", 1'b1, 8'h31, 1'b0, 1'b0);
    step("fl2_fill", 1'b1, 8'h32, 1'b0, 1'b0);
    step("fl2_wr", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush2.write",  32'(write),  32'd1);
    chk("flush2.txdata", 32'(txdata), 32'h31);
    step("fl2", 1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush2.level",  32'(level),  32'd0);
    chk("flush2.txhold", 32'(txdata), 32'h31);
    repeat (6) step("fl2_after", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the write cycle with level=3.
    do_reset();
    for (int i = 0; i < 4; i++) step("mr_fill", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step("mr_wr", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("midrst.prewrite", 32'(write), 32'd1);
    chk("midrst.prelevel", 32'(level), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("midrst.write",    32'(write),    32'd0);
    chk("midrst.level",    32'(level),    32'd0);
    chk("midrst.txdata",   32'(txdata),   32'h00);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.busy",     32'(busy),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step("mr_after", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("midrst.nostale", 32'(write), 32'd0);
    end

    // Randomized traffic with alternating drain-heavy and fill-heavy phases.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic v, te, fl;
      logic [7:0] d;
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      te = ((c / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 99) == 0);
      step("rand", v, d, te, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
